// File: rtl/trap_controller.sv
// Trap sequencer: serialises trap-entry CSR saves (uepc, ucause, utval, ustatus)
// and uret's ustatus restore onto the single CSR write port, then redirects the PC.
module trap_controller (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [3:0]  iExcReq,
  input  logic [2:0]  iIntReq,
  input  logic        iURET,
  input  logic [31:0] iPC,
  input  logic [31:0] iTval,
  input  logic [31:0] iUSTATUS,
  input  logic [31:0] iUIE,
  input  logic [31:0] iUTVEC,
  input  logic [31:0] iUEPC,
  output logic        oCSRWe,
  output logic [6:0]  oCSRNum,
  output logic [31:0] oCSRData,
  output logic        oBusy,
  output logic        oFlush,
  output logic        oPCSel,
  output logic [31:0] oTrapPC
);

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RESTORE, REDIRECT
  } state_e;

  localparam logic [6:0] CSR_USTATUS = 7'd0;
  localparam logic [6:0] CSR_UEPC    = 7'd65;
  localparam logic [6:0] CSR_UCAUSE  = 7'd66;
  localparam logic [6:0] CSR_UTVAL   = 7'd67;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;       // faulting PC on a trap, saved uepc on uret
  logic [31:0] tval_q, tval_d;
  logic [31:0] status_q, status_d;
  logic [31:0] tvec_q, tvec_d;
  logic        ret_q, ret_d;

  logic [2:0]  int_ok;
  logic [31:0] tvec_base;

  assign int_ok    = iIntReq & {iUIE[8], iUIE[4], iUIE[0]} & {3{iUSTATUS[0]}};
  assign tvec_base = tvec_q & ~32'h3;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      status_q <= '0;
      tvec_q   <= '0;
      ret_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values.
      state_q  <= state_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
      status_q <= status_d;
      tvec_q   <= tvec_d;
      ret_q    <= ret_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first so no path infers a latch.
    state_d  = state_q;
    cause_d  = cause_q;
    pc_d     = pc_q;
    tval_d   = tval_q;
    status_d = status_q;
    tvec_d   = tvec_q;
    ret_d    = ret_q;
    unique case (state_q)
      IDLE: begin
        if ((|iExcReq) || (|int_ok)) begin
          state_d  = SAVE_EPC;
          ret_d    = 1'b0;
          pc_d     = iPC;
          status_d = iUSTATUS;
          tvec_d   = iUTVEC;
          tval_d   = iTval;
          if (iExcReq[0])      cause_d = 32'd2;
          else if (iExcReq[1]) begin cause_d = 32'd8; tval_d = '0; end
          else if (iExcReq[2]) cause_d = 32'd4;
          else if (iExcReq[3]) cause_d = 32'd6;
          else begin
            tval_d = '0;
            if (int_ok[2])      cause_d = {1'b1, 31'd8};
            else if (int_ok[0]) cause_d = {1'b1, 31'd0};
            else                cause_d = {1'b1, 31'd4};
          end
        end else if (iURET) begin
          state_d  = RESTORE;
          ret_d    = 1'b1;
          pc_d     = iUEPC;
          status_d = iUSTATUS;
        end
      end
      SAVE_EPC:    state_d = SAVE_CAUSE;
      SAVE_CAUSE:  state_d = SAVE_TVAL;
      SAVE_TVAL:   state_d = SAVE_STATUS;
      SAVE_STATUS: state_d = REDIRECT;
      RESTORE:     state_d = REDIRECT;
      REDIRECT:    state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    oCSRWe   = 1'b0;
    oCSRNum  = '0;
    oCSRData = '0;
    oPCSel   = 1'b0;
    oTrapPC  = '0;
    oBusy    = (state_q != IDLE);
    oFlush   = (state_q != IDLE);
    unique case (state_q)
      SAVE_EPC:    begin oCSRWe = 1'b1; oCSRNum = CSR_UEPC;   oCSRData = pc_q;    end
      SAVE_CAUSE:  begin oCSRWe = 1'b1; oCSRNum = CSR_UCAUSE; oCSRData = cause_q; end
      SAVE_TVAL:   begin oCSRWe = 1'b1; oCSRNum = CSR_UTVAL;  oCSRData = tval_q;  end
      SAVE_STATUS: begin
        oCSRWe   = 1'b1;
        oCSRNum  = CSR_USTATUS;
        oCSRData = {status_q[31:5], status_q[0], status_q[3:1], 1'b0};
      end
      RESTORE: begin
        oCSRWe   = 1'b1;
        oCSRNum  = CSR_USTATUS;
        oCSRData = {status_q[31:5], 1'b1, status_q[3:1], status_q[4]};
      end
      REDIRECT: begin
        oPCSel = 1'b1;
        if (ret_q)
          oTrapPC = pc_q;
        else if (tvec_q[1:0] == 2'b01 && cause_q[31])
          oTrapPC = tvec_base + {cause_q[29:0], 2'b00};
        else
          oTrapPC = tvec_base;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer that turns exception and interrupt requests from the RISC-V datapath into an ordered series of single-register writes into the CSR register file, then redirects the PC. It arbitrates several simultaneous trap sources by fixed priority, saves uepc/ucause/utval/ustatus one write per cycle, and computes the handler address from utvec. It also executes uret. It sits between the core datapath (PC mux, pipeline flush/stall) and the CSR bank's single write port.

## Interface
- No parameters.
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-high
- iExcReq  in  4  synchronous exceptions: [0] illegal instr, [1] ecall, [2] load misaligned, [3] store misaligned
- iIntReq  in  3  pending interrupts: [0] software, [1] timer, [2] external
- iURET  in  1  uret instruction in execute
- iPC  in  32  PC of faulting/current instruction
- iTval  in  32  faulting address or instruction word
- iUSTATUS, iUIE, iUTVEC, iUEPC  in  32 each  current CSR values (regs 0, 4, 5, 65)
- oCSRWe  out  1  CSR write strobe
- oCSRNum  out  7  CSR index: ustatus=0, uepc=65, ucause=66, utval=67
- oCSRData  out  32  CSR write data
- oBusy  out  1  datapath must stall
- oFlush  out  1  squash in-flight instructions
- oPCSel  out  1  take oTrapPC as next PC (one cycle)
- oTrapPC  out  32  handler or return address

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RESTORE, REDIRECT.
- Interrupt eligible when iIntReq[k] & iUIE bit (software=0, timer=4, external=8) & iUSTATUS[0].
- Priority in IDLE: any exception > any eligible interrupt > iURET. Exceptions: illegal > ecall > load misaligned > store misaligned. Interrupts: external > software > timer.
- Cause codes: illegal 2, ecall 8, load misaligned 4, store misaligned 6; interrupts {1'b1, 31'd code}, codes software 0, timer 4, external 8.
- Capture in IDLE on a trap: latch cause, iPC, iTval (0 for interrupts and ecall), iUSTATUS, iUTVEC. Go to SAVE_EPC.
- SAVE_EPC: write 65 with latched PC. SAVE_CAUSE: write 66 with cause. SAVE_TVAL: write 67 with tval.
- SAVE_STATUS: write 0 with latched ustatus, bit4 (UPIE) = old bit0, bit0 (UIE) = 0; other bits unchanged.
- REDIRECT after trap: oPCSel=1; base = utvec & ~32'h3; if utvec[1:0]==2'b01 and cause is interrupt, oTrapPC = base + (code << 2), else base. Addition wraps mod 2^32. Then IDLE.
- uret in IDLE (no trap pending): latch iUSTATUS, iUEPC; RESTORE writes 0 with bit0 = old bit4, bit4 = 1; REDIRECT with oTrapPC = latched uepc; then IDLE.
- Requests arriving outside IDLE are ignored (datapath is stalled); sources must hold them until serviced.

## Timing
- Reset (async, any state): state=IDLE; all outputs 0; latches 0. A sequence interrupted by reset is abandoned; no further CSR writes.
- oCSRWe, oCSRNum, oCSRData, oPCSel, oTrapPC registered-state decoded; valid for exactly the cycle in that state.
- Trap: capture edge T0; writes on cycles T0+1..T0+4 (EPC, CAUSE, TVAL, STATUS), oPCSel at T0+5; IDLE at T0+6. Earliest new capture edge T0+6.
- uret: RESTORE at T0+1, oPCSel at T0+2, IDLE at T0+3.
- oBusy = 1 in every non-IDLE state; 0 in IDLE. oFlush = 1 in every non-IDLE state.
- Exactly one CSR write per cycle; oCSRWe=0 in IDLE and REDIRECT.
- Simultaneous exception and uret: exception taken, uret dropped. Simultaneous exception and interrupt: exception taken; interrupt serviced later if still pending.

## Test plan
- Reset mid-SAVE_CAUSE -> next cycle oCSRWe=0, oBusy=0, state IDLE; no write to 67 or 0.
- iExcReq=4'b0010, iPC=0x0040_0010, iUTVEC=0x0040_0100, iUSTATUS=1 -> writes 65=0x0040_0010, 66=8, 67=0, 0=0x10; oPCSel at T0+5 with oTrapPC=0x0040_0100.
- iExcReq=4'b1001 with iIntReq=3'b100 eligible -> ucause=2; utval=iTval.
- iIntReq=3'b010, iUIE=0x10, iUSTATUS=1, iUTVEC=0x0040_0101 -> ucause=0x8000_0004, oTrapPC=0x0040_0110; with iUSTATUS=0 -> no trap, oBusy stays 0.
- iIntReq=3'b111 all enabled -> ucause=0x8000_0008.
- iURET, iUSTATUS=0x10, iUEPC=0x0040_0014 -> write 0=0x11 at T0+1, oPCSel with oTrapPC=0x0040_0014 at T0+2; iURET with iExcReq[0] -> trap taken, ucause=2.
